// File: rtl/deserializer_rx_if.sv
// rtl/deserializer_rx_if.sv - serial line, control and parallel result bundle for deserializer_rx
interface deserializer_rx_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic              rx_in;
    logic [5:0]        prescale;
    logic [DATA_W-1:0] p_data;
    logic              data_valid;
    logic              stop_err;
    logic              busy;

    modport master (
        output en, rx_in, prescale,
        input  p_data, data_valid, stop_err, busy
    );

    modport slave (
        input  en, rx_in, prescale,
        output p_data, data_valid, stop_err, busy
    );
endinterface

// File: rtl/deserializer_rx.sv
// rtl/deserializer_rx.sv - oversampled LSB-first serial receiver with 2-of-3 majority bit decisions
module deserializer_rx #(
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    deserializer_rx_if.slave bus
);
    localparam int            BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [5:0]        p_reg;
    logic [5:0]        p_next;
    logic [5:0]        edge_cnt;
    logic [5:0]        half;
    logic [BW-1:0]     bit_cnt;
    logic [2:0]        samples;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] p_data_r;
    logic              data_valid_r;
    logic              stop_err_r;
    logic              last_edge;
    logic              bit_val;
    logic              load_p;
    logic              frame_ok;
    logic              frame_err;

    assign half      = {1'b0, p_reg[5:1]};
    assign last_edge = (edge_cnt == p_reg - 6'd1);
    assign bit_val   = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);
    // Anything other than the three supported ratios falls back to 8x.
    assign p_next    = (bus.prescale == 6'd8 || bus.prescale == 6'd16 ||
                        bus.prescale == 6'd32) ? bus.prescale : 6'd8;

    always_comb begin
        state_nxt = state;
        load_p    = 1'b0;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        if (!bus.en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.rx_in) begin
                        state_nxt = START;
                        load_p    = 1'b1;
                    end
                end
                START: begin
                    if (last_edge) state_nxt = bit_val ? IDLE : DATA;
                end
                DATA: begin
                    if (last_edge && bit_cnt == LAST_BIT) state_nxt = STOP;
                end
                STOP: begin
                    if (last_edge) begin
                        state_nxt = IDLE;
                        frame_ok  = bit_val;
                        frame_err = ~bit_val;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            p_reg <= 6'd8;
        end else begin
            state <= state_nxt;
            if (load_p) p_reg <= p_next;
        end
    end

    // Counters restart on entry to START and whenever the frame is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (state == IDLE || state_nxt == IDLE || last_edge) edge_cnt <= '0;
            else                                                  edge_cnt <= edge_cnt + 6'd1;
            if (state != DATA || state_nxt != DATA) bit_cnt <= '0;
            else if (last_edge)                     bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samples   <= '0;
            shift_reg <= '0;
        end else begin
            if (state != IDLE) begin
                if (edge_cnt == half - 6'd1) samples[0] <= bus.rx_in;
                if (edge_cnt == half)        samples[1] <= bus.rx_in;
                if (edge_cnt == half + 6'd1) samples[2] <= bus.rx_in;
            end
            if (state == DATA && last_edge && bus.en)
                shift_reg <= {bit_val, shift_reg[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_data_r     <= '0;
            data_valid_r <= 1'b0;
            stop_err_r   <= 1'b0;
        end else begin
            data_valid_r <= frame_ok;
            stop_err_r   <= frame_err;
            if (frame_ok) p_data_r <= shift_reg;
        end
    end

    assign bus.p_data     = p_data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.stop_err   = stop_err_r;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_deserializer_rx.sv
// tb/tb_deserializer_rx.sv - directed frames against a line-history receive model for deserializer_rx
module tb_deserializer_rx;
    localparam int DW   = 8;
    localparam int MAXC = 16383;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic       samp [0:MAXC];
    logic       ens  [0:MAXC];
    logic       rsts [0:MAXC];
    logic [5:0] pss  [0:MAXC];

    logic          m_rcv = 1'b0;
    int            m_t = 0;
    int            m_p = 8;
    logic [DW-1:0] m_pdata = '0;
    logic [DW-1:0] asm_val;
    logic          e_dv;
    logic          e_se;

    int            dv_cnt = 0;
    int            se_cnt = 0;
    int            last_dv_cyc = 0;
    int            prev_dv_cyc = 0;
    int            last_se_cyc = 0;
    logic [DW-1:0] last_dv_val = '0;
    logic [DW-1:0] prev_dv_val = '0;
    logic          last_dv_busy = 1'b0;

    deserializer_rx_if #(.DATA_W(DW)) bus ();
    deserializer_rx #(.DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc <= MAXC) begin
            samp[cyc] = bus.rx_in;
            ens[cyc]  = bus.en;
            rsts[cyc] = rst;
            pss[cyc]  = bus.prescale;
        end
    end

    function automatic int legal_p(input logic [5:0] p);
        return (p == 6'd8 || p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    endfunction

    // Bit j of the frame (0 = start) is the majority of the line at three mid-bit edges.
    function automatic logic bitv(input int j);
        int b;
        b = m_t + j * m_p + m_p / 2;
        return (samp[b] & samp[b+1]) | (samp[b] & samp[b+2]) | (samp[b+1] & samp[b+2]);
    endfunction

    always @(negedge clk) begin
        e_dv = 1'b0;
        e_se = 1'b0;
        if (!rst || !rsts[cyc]) begin
            m_rcv   = 1'b0;
            m_pdata = '0;
        end else if (m_rcv) begin
            if (!ens[cyc]) begin
                m_rcv = 1'b0;
            end else if (cyc == m_t + m_p && bitv(0)) begin
                m_rcv = 1'b0;
            end else if (cyc == m_t + (DW + 2) * m_p) begin
                m_rcv = 1'b0;
                if (bitv(DW + 1)) begin
                    for (int i = 0; i < DW; i++) asm_val[i] = bitv(i + 1);
                    m_pdata = asm_val;
                    e_dv    = 1'b1;
                end else begin
                    e_se = 1'b1;
                end
            end
        end else if (ens[cyc] && !samp[cyc]) begin
            m_rcv = 1'b1;
            m_t   = cyc;
            m_p   = legal_p(pss[cyc]);
        end

        checks++;
        if (bus.busy !== m_rcv || bus.data_valid !== e_dv || bus.stop_err !== e_se ||
            bus.p_data !== m_pdata) begin
            errors++;
            if (errors < 30)
                $display("FAIL model cycle %0d: busy/dv/se/p_data actual %b/%b/%b/%h required %b/%b/%b/%h",
                         cyc, bus.busy, bus.data_valid, bus.stop_err, bus.p_data,
                         m_rcv, e_dv, e_se, m_pdata);
        end
        checks++;
        if (bus.data_valid === 1'b1 && bus.stop_err === 1'b1) begin
            errors++;
            $display("FAIL exclusive_pulse cycle %0d: data_valid and stop_err both 1, required not both", cyc);
        end
        if (bus.data_valid === 1'b1) begin
            prev_dv_cyc  = last_dv_cyc;
            prev_dv_val  = last_dv_val;
            last_dv_cyc  = cyc;
            last_dv_val  = bus.p_data;
            last_dv_busy = bus.busy;
            dv_cnt++;
        end
        if (bus.stop_err === 1'b1) begin
            last_se_cyc = cyc;
            se_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one line frame of 10*p cycles; optional one-cycle glitch at mid-bit, mid-frame
    // prescale change, or an abort (kind 0 = reset pulse, 1 = enable drop) at a bit boundary.
    task automatic send_frame(input logic [7:0] d, input int p, input logic stop,
                              input int glitch_bit, input int abort_bit, input int abort_kind,
                              input logic [5:0] ps_mid, output int c0);
        logic [5:0] ps_orig;
        logic       v;
        ps_orig = bus.prescale;
        c0 = cyc;
        for (int j = 0; j < 10; j++) begin
            v = (j == 0) ? 1'b0 : (j == 9) ? stop : d[j-1];
            for (int m = 0; m < p; m++) begin
                if (j == abort_bit && m == 0) begin
                    bus.rx_in = 1'b1;
                    if (abort_kind == 0) rst = 1'b0;
                    else                 bus.en = 1'b0;
                    step(3);
                    rst    = 1'b1;
                    bus.en = 1'b1;
                    return;
                end
                if (ps_mid != 6'd0 && m == 0) begin
                    if (j == 4) bus.prescale = ps_mid;
                    if (j == 9) bus.prescale = ps_orig;
                end
                bus.rx_in = (j == glitch_bit && m == p / 2 + 1) ? 1'b0 : v;
                step(1);
            end
        end
        bus.rx_in = 1'b1;
    endtask

    initial begin
        int c;
        int c1;
        int dv0;
        bus.en       = 1'b1;
        bus.rx_in    = 1'b1;
        bus.prescale = 6'd8;
        rst          = 1'b0;
        step(3);
        chk("reset_p_data", bus.p_data, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_data_valid", bus.data_valid, 0);
        rst = 1'b1;
        step(5);

        send_frame(8'hA5, 8, 1'b1, -1, -1, 0, 6'd0, c);
        step(12);
        chk("a5_dv_cycle", last_dv_cyc, c + 81);
        chk("a5_p_data", last_dv_val, 8'hA5);
        chk("a5_busy_at_dv", last_dv_busy, 0);
        chk("a5_dv_count", dv_cnt, 1);

        bus.prescale = 6'd16;
        send_frame(8'h3C, 16, 1'b0, -1, -1, 0, 6'd0, c);
        step(20);
        chk("3c_se_cycle", last_se_cyc, c + 161);
        chk("3c_p_data_kept", bus.p_data, 8'hA5);
        chk("3c_no_dv", dv_cnt, 1);
        chk("3c_se_count", se_cnt, 1);

        bus.prescale = 6'd8;
        c = cyc;
        bus.rx_in = 1'b0;
        step(3);
        bus.rx_in = 1'b1;
        step(c + 8 - cyc);
        chk("glitch_busy_t7", bus.busy, 1);
        step(1);
        chk("glitch_idle_t8", bus.busy, 0);
        step(10);
        chk("glitch_no_pulse", dv_cnt + se_cnt, 2);
        send_frame(8'h81, 8, 1'b1, -1, -1, 0, 6'd0, c);
        step(12);
        chk("81_p_data", last_dv_val, 8'h81);
        chk("81_dv_cycle", last_dv_cyc, c + 81);

        bus.prescale = 6'd32;
        send_frame(8'hFF, 32, 1'b1, 4, -1, 0, 6'd0, c);
        step(40);
        chk("ff_majority_p_data", bus.p_data, 8'hFF);
        chk("ff_dv_cycle", last_dv_cyc, c + 321);

        bus.prescale = 6'd20;
        send_frame(8'h5A, 8, 1'b1, -1, -1, 0, 6'd0, c);
        step(12);
        chk("illegal_ps_p_data", last_dv_val, 8'h5A);
        chk("illegal_ps_dv_cycle", last_dv_cyc, c + 81);

        bus.prescale = 6'd16;
        dv0 = dv_cnt;
        send_frame(8'h12, 16, 1'b1, -1, -1, 0, 6'd8, c1);
        send_frame(8'h34, 16, 1'b1, -1, -1, 0, 6'd0, c);
        step(24);
        chk("b2b_dv_count", dv_cnt - dv0, 2);
        chk("b2b_first_val", prev_dv_val, 8'h12);
        chk("b2b_first_cycle", prev_dv_cyc, c1 + 161);
        chk("b2b_second_val", last_dv_val, 8'h34);
        chk("b2b_second_cycle", last_dv_cyc, c1 + 322);

        bus.prescale = 6'd8;
        dv0 = dv_cnt;
        send_frame(8'h55, 8, 1'b1, -1, 5, 0, 6'd0, c);
        step(20);
        chk("rst_abort_no_pulse", dv_cnt + se_cnt, dv0 + 1);
        chk("rst_abort_p_data", bus.p_data, 0);
        send_frame(8'hAA, 8, 1'b1, -1, -1, 0, 6'd0, c);
        step(12);
        chk("aa_after_rst", bus.p_data, 8'hAA);

        dv0 = dv_cnt;
        send_frame(8'h0F, 8, 1'b1, -1, 3, 1, 6'd0, c);
        step(20);
        chk("en_abort_no_pulse", dv_cnt, dv0);
        chk("en_abort_p_data", bus.p_data, 8'hAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: run still active at time limit, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
